// File: rtl/cla_wide_add_seq_pkg.sv
// Shared types and constants for the wide-add sequencer around the 16-bit CLA stage.
package cla_seq_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_wide_add_seq_if.sv
// Operand request and result response handshakes of the wide-add sequencer.
interface cla_wide_add_seq_if #(
  parameter int NCHUNK = 4
);
  import cla_seq_pkg::*;

  localparam int W = CHUNK_W * NCHUNK;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cla_wide_add_seq_chunk_sel.sv
// Picks one 16-bit chunk out of a wide operand; chunk 0 is the least significant.
module cla_chunk_sel
  import cla_seq_pkg::*;
#(
  parameter int NCHUNK = 4,
  parameter int IDX_W  = 2
) (
  input  logic [CHUNK_W*NCHUNK-1:0] word,
  input  logic [IDX_W-1:0]          idx,
  output logic [CHUNK_W-1:0]        chunk
);

  logic [NCHUNK-1:0][CHUNK_W-1:0] words;

  assign words = word;

  // Plain mux over the chunk view of the operand.
  always_comb begin
    chunk = words[idx];
  end

endmodule

// File: rtl/cla_wide_add_seq.sv
// Sequencer that drives a registered 16-bit CLA stage chunk by chunk, LSB first,
// chaining carries, and returns the wide sum, carry-out and signed overflow.
module cla_wide_add_seq
  import cla_seq_pkg::*;
#(
  parameter int NCHUNK  = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_wide_add_seq_if.slave    bus,
  output logic [CHUNK_W-1:0]   add_in1,
  output logic [CHUNK_W-1:0]   add_in2,
  output logic                 add_cnet,
  input  logic [CHUNK_W-1:0]   add_out,
  input  logic                 add_c
);

  localparam int W      = CHUNK_W * NCHUNK;
  localparam int IDX_W  = cnt_w(NCHUNK);
  localparam int WCNT_W = cnt_w(ADD_LAT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NCHUNK - 1);
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(ADD_LAT - 1);

  state_t                         state, state_nx;
  logic [W-1:0]                   a_q, a_nx;
  logic [W-1:0]                   beff_q, beff_nx;
  logic [NCHUNK-1:0][CHUNK_W-1:0] acc_q;
  logic [IDX_W-1:0]               idx_q, idx_nx;
  logic [WCNT_W-1:0]              wcnt_q;
  logic                           carry_q, carry_nx;
  logic                           accept, chunk_done;
  logic [CHUNK_W-1:0]             sel_a, sel_b;

  assign accept     = (state == IDLE) && bus.in_valid && bus.in_ready;
  assign chunk_done = (state == WAIT) && (wcnt_q == '0);

  // Adder operands are registered on the edge that enters ISSUE, so they are
  // selected from the next-cycle operand/index values.
  cla_chunk_sel #(.NCHUNK(NCHUNK), .IDX_W(IDX_W)) u_sel_a (
    .word (a_nx),
    .idx  (idx_nx),
    .chunk(sel_a)
  );

  cla_chunk_sel #(.NCHUNK(NCHUNK), .IDX_W(IDX_W)) u_sel_b (
    .word (beff_nx),
    .idx  (idx_nx),
    .chunk(sel_b)
  );

  // Next state plus next operand/carry/index values.
  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    beff_nx  = beff_q;
    carry_nx = carry_q;
    idx_nx   = idx_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = ISSUE;
          a_nx     = bus.a;
          beff_nx  = bus.sub ? ~bus.b : bus.b;
          carry_nx = bus.sub | bus.cin;
          idx_nx   = '0;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (wcnt_q == '0) begin
          carry_nx = add_c;
          if (idx_q == LAST_IDX) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx_q + 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      DONE: begin
        if (bus.out_valid && bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Latched operands, carry chain, chunk index, adder wait counter and partial sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      beff_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      acc_q   <= '0;
    end else begin
      a_q     <= a_nx;
      beff_q  <= beff_nx;
      carry_q <= carry_nx;
      idx_q   <= idx_nx;
      if (state == ISSUE)                        wcnt_q <= WCNT_LOAD;
      else if (state == WAIT && wcnt_q != '0)    wcnt_q <= wcnt_q - 1'b1;
      if (chunk_done) acc_q[idx_q] <= add_out;
    end
  end

  // Adder inputs: loaded when entering ISSUE and held through WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_in1  <= '0;
      add_in2  <= '0;
      add_cnet <= 1'b0;
    end else if (state_nx == ISSUE) begin
      add_in1  <= sel_a;
      add_in2  <= sel_b;
      add_cnet <= carry_nx;
    end
  end

  // Handshake outputs; the result is registered on the first DONE cycle and
  // then held until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.in_ready <= (state_nx == IDLE);
      if (state == DONE && !bus.out_valid) begin
        bus.out_valid <= 1'b1;
        bus.sum       <= acc_q;
        bus.cout      <= carry_q;
        bus.ovf       <= (a_q[W-1] == beff_q[W-1]) &&
                         (acc_q[NCHUNK-1][CHUNK_W-1] != a_q[W-1]);
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
